rr_arbiter: RTL

Round-robin arbiter sharing one sequential resource (e.g. a table-driven FSM datapath) between up to N requesters. Samples a request vector, issues one registered one-hot grant, holds it until the owner releases or an optional hold timer expires, then rotates priority past the last owner. Sits between the requesting units and the shared resource's input mux / enable.

---
 rtl/rr_arbiter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter for one shared sequential resource.
// Samples req in IDLE, issues a registered one-hot grant held until the owner
// releases (rel=1 or its request drops), inserts one GAP cycle, then rotates
// priority past the last owner.
// Optional feature macro: ARB_TIMEOUT_EN -- when defined, a hold counter
// revokes a grant after MAX_HOLD cycles and pulses timeout for one cycle.
// When undefined, no counter exists and timeout is tied to 0.
module rr_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  localparam int OW      = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          rel,
  output logic [N-1:0]  gnt,
  output logic [OW-1:0] owner,
  output logic          busy,
  output logic          timeout
);

  // Reject configurations outside the supported range at elaboration.
  if (N < 2 || N > 8 || MAX_HOLD < 2) begin : g_param_check
    $error("rr_arbiter: N must be 2..8 and MAX_HOLD must be >= 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  state_e        state_r, state_s;
  logic [OW-1:0] ptr_r, ptr_s;
  logic [OW-1:0] owner_r, owner_s;
  logic [N-1:0]  gnt_r, gnt_s;
  logic          busy_r, busy_s;
  logic [OW-1:0] winner_s;
  logic          found_s;
  logic          release_s;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          timeout_r, timeout_s;
`endif

  // Wrap-around successor of an owner index (priority rotates past it).
  function automatic logic [OW-1:0] next_idx(input logic [OW-1:0] idx);
    logic [OW-1:0] nxt;
    if (int'(idx) == N - 1) begin
      nxt = {OW{1'b0}};
    end else begin
      nxt = idx + {{(OW-1){1'b0}}, 1'b1};
    end
    return nxt;
  endfunction

  // One-hot vector with bit idx set.
  function automatic logic [N-1:0] one_hot(input logic [OW-1:0] idx);
    logic [N-1:0] v;
    v = {{(N-1){1'b0}}, 1'b1} << idx;
    return v;
  endfunction

  // Round-robin search: first set request bit at ptr, ptr+1, ... mod N.
  always_comb begin : p_search
    int unsigned pos;
    winner_s = {OW{1'b0}};
    found_s  = 1'b0;
    pos      = 0;
    for (int i = 0; i < N; i++) begin
      pos = (int'(ptr_r) + i) % N;
      if (!found_s && req[pos[OW-1:0]]) begin
        found_s  = 1'b1;
        winner_s = pos[OW-1:0];
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Owner gives up the resource by strobing rel or dropping its request.
  assign release_s = rel | ~req[owner_r];

  // Next-state and next-output logic for the IDLE/HOLD/GAP sequence.
  always_comb begin
    state_s   = state_r;
    ptr_s     = ptr_r;
    owner_s   = owner_r;
    gnt_s     = gnt_r;
    busy_s    = busy_r;
`ifdef ARB_TIMEOUT_EN
    cnt_s     = cnt_r;
    timeout_s = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (found_s) begin
          state_s = ST_HOLD;
          gnt_s   = one_hot(winner_s);
          owner_s = winner_s;
          busy_s  = 1'b1;
          ptr_s   = next_idx(winner_s);
`ifdef ARB_TIMEOUT_EN
          cnt_s   = {CW{1'b0}};
`endif
        end else begin
          gnt_s   = {N{1'b0}};
          busy_s  = 1'b0;
        end
      end
      ST_HOLD: begin
        // Release takes precedence over timer expiry.
        if (release_s) begin
          state_s = ST_GAP;
          gnt_s   = {N{1'b0}};
          busy_s  = 1'b0;
`ifdef ARB_TIMEOUT_EN
        end else if (cnt_r == CW'(MAX_HOLD - 1)) begin
          state_s   = ST_GAP;
          gnt_s     = {N{1'b0}};
          busy_s    = 1'b0;
          timeout_s = 1'b1;
        end else begin
          cnt_s     = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
`else
        end else begin
          state_s = ST_HOLD;
        end
`endif
      end
      ST_GAP: begin
        state_s = ST_IDLE;
        gnt_s   = {N{1'b0}};
        busy_s  = 1'b0;
      end
      default: begin
        state_s = ST_IDLE;
        gnt_s   = {N{1'b0}};
        busy_s  = 1'b0;
      end
    endcase
  end

  // State, priority pointer and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      ptr_r     <= {OW{1'b0}};
      owner_r   <= {OW{1'b0}};
      gnt_r     <= {N{1'b0}};
      busy_r    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_r     <= {CW{1'b0}};
      timeout_r <= 1'b0;
`endif
    end else begin
      state_r   <= state_s;
      ptr_r     <= ptr_s;
      owner_r   <= owner_s;
      gnt_r     <= gnt_s;
      busy_r    <= busy_s;
`ifdef ARB_TIMEOUT_EN
      cnt_r     <= cnt_s;
      timeout_r <= timeout_s;
`endif
    end
  end

  assign gnt   = gnt_r;
  assign owner = owner_r;
  assign busy  = busy_r;
`ifdef ARB_TIMEOUT_EN
  assign timeout = timeout_r;
`else
  assign timeout = 1'b0;
`endif

endmodule
